match_run_detector: RTL
=======================

# match_run_detector

Parametrised successor to the two-input equality detector FSM. Compares two WIDTH-bit buses under a per-bit mask each enabled cycle and counts consecutive matching samples. Asserts a detect flag once the run reaches a programmable threshold, with an optional sticky mode. Sits at the front of the compare/sequence-detect path, feeding downstream control logic.

## Interface

Parameters:
- WIDTH, 4, bit width of compared buses and mask
- CNT_W, 4, width of run counter and threshold

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  sample enable; 0 = all state holds
- clr  in  1  synchronous clear of run count and detect
- a_in  in  WIDTH  operand A
- b_in  in  WIDTH  operand B
- mask  in  WIDTH  compare mask; 1 = bit participates
- thresh  in  CNT_W  required run length; 0 treated as 1
- sticky  in  1  1 = detect holds through mismatches until clr
- y_out  out  1  detect flag (registered)
- run_len  out  CNT_W  current consecutive match count, saturating
- first_hit  out  1  one-cycle pulse when y_out rises

## Operation

- match = ((a_in ^ b_in) & mask) == 0; mask all-zero => always match.
- eff_thresh = (thresh == 0) ? 1 : thresh; sampled combinationally on every enabled cycle.
- run_next = saturate(run_len + 1) at 2^CNT_W - 1; never wraps.
- States:
  - IDLE: run_len = 0, y_out = 0
  - RUN: 0 < run_len < eff_thresh, y_out = 0
  - HIT: run_len >= eff_thresh, y_out = 1
  - LATCH: sticky hold, run_len counts a fresh run, y_out = 1
- Transitions, en=1 and clr=0:
  - match, any state except LATCH: run_len <= run_next; go to HIT if run_next >= eff_thresh, else RUN.
  - match in LATCH: run_len <= run_next; go to HIT if run_next >= eff_thresh, else stay in LATCH if sticky, else RUN.
  - mismatch, in HIT or LATCH with sticky=1: go to LATCH, run_len <= 0.
  - mismatch, otherwise: go to IDLE, run_len <= 0.
- en=0: state, run_len and y_out hold; first_hit <= 0.
- Priority: rst > clr > en. clr=1 forces IDLE, run_len = 0, first_hit = 0, regardless of en.
- first_hit <= 1 only on a clock edge where y_out goes 0→1. No pulse on HIT↔LATCH moves, since y_out stays 1.
- sticky deasserted while in LATCH: the next enabled sample resolves normally (mismatch → IDLE).

## Timing

- Reset values: y_out = 0, run_len = 0, first_hit = 0, state = IDLE. All apply immediately on rst assertion, mid-run included.
- Latency: a sample taken at edge k is reflected on outputs after edge k.
- With thresh=1, y_out rises one cycle after the first matching sample and falls one cycle after a mismatch. This is the legacy equality-detector behaviour.
- A threshold change takes effect at the next enabled sample. y_out is never recomputed combinationally from thresh.
- Saturated run: run_len holds all-ones; y_out stays 1 while matches continue.
- clr and rst released: the first enabled sample starts from IDLE.

## Test plan

- Reset mid-run: rst pulses while run_len=2 → y_out=0, run_len=0, first_hit=0 asynchronously; the next match gives run_len=1.
- Basic run, WIDTH=4, thresh=3, mask=4'hF: a=b=4'h5 for 3 enabled cycles → run_len 1,2,3; y_out=1 and first_hit=1 after the 3rd edge, first_hit=0 the next cycle. Then a=4'h5, b=4'h4 → y_out=0, run_len=0.
- Mask: mask=4'b0011, a=4'b1101, b=4'b0001 → match, run_len increments. Then b=4'b0000 → mismatch, run_len=0.
- Sticky, thresh=2, sticky=1: 2 matches then mismatch → y_out stays 1, run_len=0, no second first_hit. Then clr=1 → y_out=0 next edge.
- Saturation, CNT_W=4, thresh=15: 20 consecutive matches → run_len stops at 15; y_out=1 from the 15th edge on.
- Gating and zero threshold: en=0 for 5 cycles with mismatched inputs → outputs unchanged. Then thresh=0, en=1, one match → y_out=1 after one edge.

Source files
------------

// File: rtl/match_run_detector.sv
// rtl/match_run_detector.sv - masked bus-equality run counter with threshold detect
// Counts consecutive enabled matching samples and flags once the run reaches thresh.
module match_run_detector #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] mask,
  input  logic [CNT_W-1:0] thresh,
  input  logic             sticky,
  output logic             y_out,
  output logic [CNT_W-1:0] run_len,
  output logic             first_hit
);

  typedef enum logic [1:0] {IDLE, RUN, HIT, LATCH} state_t;

  state_t           state;
  state_t           state_nx;
  logic             match;
  logic [CNT_W-1:0] eff_thresh;
  logic [CNT_W-1:0] run_next;
  logic [CNT_W-1:0] run_nx;
  logic             y_nx;

  assign match      = ((a_in ^ b_in) & mask) == '0;
  assign eff_thresh = (thresh == '0) ? CNT_W'(1) : thresh;
  assign run_next   = (run_len == '1) ? run_len : run_len + CNT_W'(1);

  always_comb begin
    state_nx = IDLE;
    run_nx   = '0;
    y_nx     = 1'b0;
    if (match) begin
      run_nx = run_next;
      if (run_next >= eff_thresh) begin
        state_nx = HIT;
        y_nx     = 1'b1;
      end else if (state == LATCH && sticky) begin
        state_nx = LATCH;
        y_nx     = 1'b1;
      end else begin
        state_nx = RUN;
      end
    end else if ((state == HIT || state == LATCH) && sticky) begin
      // Sticky mismatch keeps the flag but restarts the run count.
      state_nx = LATCH;
      y_nx     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      run_len   <= '0;
      y_out     <= 1'b0;
      first_hit <= 1'b0;
    end else if (clr) begin
      state     <= IDLE;
      run_len   <= '0;
      y_out     <= 1'b0;
      first_hit <= 1'b0;
    end else if (en) begin
      state     <= state_nx;
      run_len   <= run_nx;
      y_out     <= y_nx;
      first_hit <= y_nx && !y_out;
    end else begin
      first_hit <= 1'b0;
    end
  end

endmodule
